// File: rtl/cache_port_arbiter.sv
// rtl/cache_port_arbiter.sv - round-robin two-port arbiter and sequencer for the cache request port
module cache_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          iReq0,
  input  logic          iReq1,
  input  logic          iWe0,
  input  logic          iWe1,
  input  logic [AW-1:0] iAddr0,
  input  logic [AW-1:0] iAddr1,
  input  logic [DW-1:0] iData0,
  input  logic [DW-1:0] iData1,
  output logic          oGnt0,
  output logic          oGnt1,
  output logic          oDone0,
  output logic          oDone1,
  output logic [DW-1:0] oRData0,
  output logic [DW-1:0] oRData1,
  output logic          oHit0,
  output logic          oHit1,
  output logic          oErr0,
  output logic          oErr1,
  output logic          oCacheRd,
  output logic          oCacheWr,
  output logic [AW-1:0] oCacheAddr,
  output logic [DW-1:0] oCacheData,
  input  logic [DW-1:0] iCacheData,
  input  logic          iCacheReady,
  input  logic          iCacheHit
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  state_t        state, nextState;
  logic          sel, last;
  logic [TW-1:0] timer;
  logic          winner, anyReq, timerEnd, finish;

  // Tie goes to the port that was not served last.
  assign anyReq   = iReq0 | iReq1;
  assign winner   = (iReq0 & iReq1) ? ~last : iReq1;
  assign timerEnd = (timer == TLAST);
  assign finish   = iCacheReady | timerEnd;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (anyReq) nextState = ISSUE;
      ISSUE:   nextState = WAIT;
      WAIT:    if (finish) nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // The cache address/data registers double as the captured request; they hold through WAIT.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sel        <= 1'b0;
      last       <= 1'b1;
      timer      <= '0;
      oGnt0      <= 1'b0;
      oGnt1      <= 1'b0;
      oDone0     <= 1'b0;
      oDone1     <= 1'b0;
      oRData0    <= '0;
      oRData1    <= '0;
      oHit0      <= 1'b0;
      oHit1      <= 1'b0;
      oErr0      <= 1'b0;
      oErr1      <= 1'b0;
      oCacheRd   <= 1'b0;
      oCacheWr   <= 1'b0;
      oCacheAddr <= '0;
      oCacheData <= '0;
    end else begin
      oGnt0    <= 1'b0;
      oGnt1    <= 1'b0;
      oDone0   <= 1'b0;
      oDone1   <= 1'b0;
      oCacheRd <= 1'b0;
      oCacheWr <= 1'b0;
      case (state)
        IDLE: begin
          if (anyReq) begin
            sel        <= winner;
            oGnt0      <= ~winner;
            oGnt1      <= winner;
            oCacheRd   <= winner ? ~iWe1 : ~iWe0;
            oCacheWr   <= winner ? iWe1 : iWe0;
            oCacheAddr <= winner ? iAddr1 : iAddr0;
            oCacheData <= winner ? iData1 : iData0;
          end
        end
        ISSUE: timer <= '0;
        WAIT: begin
          // A ready on the terminal count wins over the timeout.
          if (finish) begin
            if (sel) begin
              oDone1  <= 1'b1;
              oRData1 <= iCacheReady ? iCacheData : '0;
              oHit1   <= iCacheReady & iCacheHit;
              oErr1   <= ~iCacheReady;
            end else begin
              oDone0  <= 1'b1;
              oRData0 <= iCacheReady ? iCacheData : '0;
              oHit0   <= iCacheReady & iCacheHit;
              oErr0   <= ~iCacheReady;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DONE: last <= sel;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_port_arbiter.sv
// tb/tb_cache_port_arbiter.sv - scoreboard bench for cache_port_arbiter
module tb_cache_port_arbiter;

  localparam int TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        iReq0 = 1'b0, iReq1 = 1'b0, iWe0 = 1'b0, iWe1 = 1'b0;
  logic [31:0] iAddr0 = '0, iAddr1 = '0, iData0 = '0, iData1 = '0;
  logic        oGnt0, oGnt1, oDone0, oDone1, oHit0, oHit1, oErr0, oErr1;
  logic [31:0] oRData0, oRData1;
  logic        oCacheRd, oCacheWr;
  logic [31:0] oCacheAddr, oCacheData;
  logic [31:0] iCacheData = '0;
  logic        iCacheReady = 1'b0, iCacheHit = 1'b0;

  always #5 clk = ~clk;

  cache_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .resetn(resetn),
    .iReq0(iReq0), .iReq1(iReq1), .iWe0(iWe0), .iWe1(iWe1),
    .iAddr0(iAddr0), .iAddr1(iAddr1), .iData0(iData0), .iData1(iData1),
    .oGnt0(oGnt0), .oGnt1(oGnt1), .oDone0(oDone0), .oDone1(oDone1),
    .oRData0(oRData0), .oRData1(oRData1), .oHit0(oHit0), .oHit1(oHit1),
    .oErr0(oErr0), .oErr1(oErr1), .oCacheRd(oCacheRd), .oCacheWr(oCacheWr),
    .oCacheAddr(oCacheAddr), .oCacheData(oCacheData),
    .iCacheData(iCacheData), .iCacheReady(iCacheReady), .iCacheHit(iCacheHit)
  );

  typedef struct {bit we; logic [31:0] addr; logic [31:0] data;} req_t;
  typedef struct {bit port; bit we; logic [31:0] addr; logic [31:0] data; int delay; int gap;} gnt_t;
  typedef struct {bit port; logic [31:0] rdata; bit hit; bit err; int lat;} done_t;

  req_t  reqQ0[$], reqQ1[$];
  gnt_t  gntQ[$];
  done_t doneQ[$];
  logic [31:0] mem [logic [31:0]];

  int checks = 0, errors = 0;
  int cyc = 0, gntCyc = 0, lastDoneCyc = 0, pendCnt = 0;
  bit busy0 = 0, busy1 = 0, pendHit = 0;
  logic [31:0] pendData = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected grant/completion are queued in the order the arbiter must serve them.
  task automatic txn(input bit port, input bit we, input logic [31:0] addr, input logic [31:0] data,
                     input int delay, input int gap, input logic [31:0] rdata, input bit hit,
                     input bit err, input int lat);
    req_t r;
    r = '{we, addr, data};
    if (port) reqQ1.push_back(r);
    else      reqQ0.push_back(r);
    gntQ.push_back('{port, we, addr, data, delay, gap});
    doneQ.push_back('{port, rdata, hit, err, lat});
  endtask

  task automatic waitDrain(input string tag);
    int n = 0;
    while ((gntQ.size() > 0 || doneQ.size() > 0 || reqQ0.size() > 0 || reqQ1.size() > 0 ||
            busy0 || busy1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(n < 200), 64'd1);
  endtask

  // Monitor, cache model and requesters, all on the falling edge.
  always @(negedge clk) begin
    gnt_t  g;
    done_t d;
    req_t  r;
    cyc++;
    iCacheReady = 1'b0;
    if (pendCnt > 0) begin
      pendCnt--;
      if (pendCnt == 0) begin
        iCacheReady = 1'b1;
        iCacheData  = pendData;
        iCacheHit   = pendHit;
      end
    end
    if (oGnt0 | oGnt1) begin
      if (gntQ.size() == 0) check("unexp_gnt", 64'd1, 64'd0);
      else begin
        g = gntQ.pop_front();
        check("gnt_port", 64'({oGnt1, oGnt0}), g.port ? 64'd2 : 64'd1);
        check("gnt_rdwr", 64'({oCacheRd, oCacheWr}), g.we ? 64'd1 : 64'd2);
        check("gnt_addr", 64'(oCacheAddr), 64'(g.addr));
        if (g.we) check("gnt_wdata", 64'(oCacheData), 64'(g.data));
        if (g.gap >= 0) check("gnt_gap", 64'(cyc - lastDoneCyc), 64'(g.gap));
        gntCyc   = cyc;
        pendHit  = mem.exists(oCacheAddr);
        pendData = pendHit ? mem[oCacheAddr] : 32'h0;
        if (g.we) mem[oCacheAddr] = oCacheData;
        pendCnt = g.delay;
      end
    end else begin
      check("rdwr_idle", 64'({oCacheRd, oCacheWr}), 64'd0);
    end
    if (oDone0 | oDone1) begin
      if (doneQ.size() == 0) check("unexp_done", 64'd1, 64'd0);
      else begin
        d = doneQ.pop_front();
        check("done_port", 64'({oDone1, oDone0}), d.port ? 64'd2 : 64'd1);
        check("done_rdata", 64'(d.port ? oRData1 : oRData0), 64'(d.rdata));
        check("done_hit", 64'(d.port ? oHit1 : oHit0), 64'(d.hit));
        check("done_err", 64'(d.port ? oErr1 : oErr0), 64'(d.err));
        check("done_lat", 64'(cyc - gntCyc), 64'(d.lat));
      end
      lastDoneCyc = cyc;
    end
    if (!resetn) begin
      busy0 = 0; busy1 = 0; iReq0 = 1'b0; iReq1 = 1'b0; pendCnt = 0;
      mem.delete();
    end else begin
      if (busy0 && oDone0) begin busy0 = 0; iReq0 = 1'b0; end
      if (busy1 && oDone1) begin busy1 = 0; iReq1 = 1'b0; end
      if (!busy0 && reqQ0.size() > 0) begin
        r = reqQ0.pop_front();
        iReq0 = 1'b1; iWe0 = r.we; iAddr0 = r.addr; iData0 = r.data; busy0 = 1;
      end
      if (!busy1 && reqQ1.size() > 0) begin
        r = reqQ1.pop_front();
        iReq1 = 1'b1; iWe1 = r.we; iAddr1 = r.addr; iData1 = r.data; busy1 = 1;
      end
    end
  end

  initial begin
    int n;
    req_t r;
    repeat (3) @(negedge clk);
    check("rst_outs", 64'(|{oGnt0, oGnt1, oDone0, oDone1, oRData0, oRData1, oHit0, oHit1,
                           oErr0, oErr1, oCacheRd, oCacheWr, oCacheAddr, oCacheData}), 64'd0);
    resetn = 1'b1;
    @(negedge clk);

    // First tie after reset: port 0 first, one IDLE cycle, then port 1.
    txn(0, 0, 32'h40, 32'h0, 1, -1, 32'h0, 0, 0, 2);
    txn(1, 0, 32'h80, 32'h0, 1, 2, 32'h0, 0, 0, 2);
    waitDrain("drain_tie");

    // Both ports held: strict 0,1 alternation, port 1 reads what port 0 just wrote.
    for (int i = 0; i < 4; i++) begin
      txn(0, 1, 32'h200 + 32'(4 * i), 32'hA000 + 32'(i), 1 + i % 3, (i == 0) ? -1 : 2,
          32'h0, 0, 0, 2 + i % 3);
      txn(1, 0, 32'h200 + 32'(4 * i), 32'h0, 1 + i % 2, 2, 32'hA000 + 32'(i), 1, 0, 2 + i % 2);
    end
    waitDrain("drain_fair");

    txn(1, 1, 32'hFDEF_1000, 32'h1234_5678, 2, -1, 32'h0, 0, 0, 3);
    waitDrain("drain_wr");
    txn(0, 0, 32'hFDEF_1000, 32'h0, 1, -1, 32'h1234_5678, 1, 0, 2);
    waitDrain("drain_rd");

    // Ready exactly at the terminal count is a success.
    txn(1, 0, 32'hFDEF_1000, 32'h0, TIMEOUT, -1, 32'h1234_5678, 1, 0, TIMEOUT + 1);
    waitDrain("drain_edge");
    txn(1, 0, 32'h500, 32'h0, 0, -1, 32'h0, 0, 1, TIMEOUT + 1);
    waitDrain("drain_tmo");
    txn(0, 0, 32'hFDEF_1000, 32'h0, 1, -1, 32'h1234_5678, 1, 0, 2);
    waitDrain("drain_after_tmo");

    // Reset three cycles into a WAIT that never completes.
    r = '{1'b0, 32'h40, 32'h0};
    reqQ0.push_back(r);
    gntQ.push_back('{1'b0, 1'b0, 32'h40, 32'h0, 0, -1});
    n = 0;
    while (gntQ.size() > 0 && n < 50) begin @(negedge clk); n++; end
    check("rst_gnt_seen", 64'(n < 50), 64'd1);
    repeat (3) @(negedge clk);
    #2 resetn = 1'b0;
    #1 check("rst_mid_outs", 64'(|{oGnt0, oGnt1, oDone0, oDone1, oRData0, oRData1, oHit0, oHit1,
                                  oErr0, oErr1, oCacheRd, oCacheWr, oCacheAddr, oCacheData}), 64'd0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    txn(1, 0, 32'h80, 32'h0, 1, -1, 32'h0, 0, 0, 2);
    waitDrain("drain_post_rst");
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
